// File: rtl/reg_file.sv
// 32 x DATA_W register file with x0 hardwired to zero, async active-low reset, two combinational read ports.
// Optional same-cycle write-to-read forwarding when REG_FILE_WRITE_BYPASS_EN is defined.
module reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  // x0 has no storage; the bank starts at index 1.
  logic [DATA_W-1:0]   regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   rs1_stored;
  logic [DATA_W-1:0]   rs2_stored;

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (wr_en && (rd_addr == ADDR_W'(i))) wr_sel[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (wr_sel[i]) regs[i] <= wr_data;
      end
    end
  end

  // Index 0 matches no bank entry, so it falls through to the zero default.
  always_comb begin
    rs1_stored = '0;
    rs2_stored = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (rs1_addr == ADDR_W'(i)) rs1_stored = regs[i];
      if (rs2_addr == ADDR_W'(i)) rs2_stored = regs[i];
    end
  end

`ifdef REG_FILE_WRITE_BYPASS_EN
  logic wr_live;

  // Forwarding is suppressed during reset so reads still show the cleared bank.
  assign wr_live  = rst_n && wr_en && (rd_addr != '0);
  assign rs1_data = (wr_live && (rd_addr == rs1_addr)) ? wr_data : rs1_stored;
  assign rs2_data = (wr_live && (rd_addr == rs2_addr)) ? wr_data : rs2_stored;
`else
  assign rs1_data = rs1_stored;
  assign rs2_data = rs2_stored;
`endif

endmodule
